rrf_alloc_ctrl: RTL

RRF_ALLOC_CTRL -- requirements
Module: rrf_alloc_ctrl

---
 rtl/rrf_alloc_ctrl_pkg.sv | 12 +
 rtl/rrf_alloc_ctrl_if.sv | 28 ++
 rtl/rrf_alloc_ctrl.sv | 92 +++++++++
 3 files changed

// File: rtl/rrf_alloc_ctrl_pkg.sv
// Shared constants for the rename-register-file allocator: default geometry and FSM encoding.
package rrf_alloc_ctrl_pkg;

  localparam int RRF_ENT_NUM_DEF = 64;
  localparam int RRF_ENT_SEL_DEF = 6;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_e;

endpackage

// File: rtl/rrf_alloc_ctrl_if.sv
// Dispatch / commit / status bundle between the dispatch stage and the RRF allocator.
interface rrf_alloc_ctrl_if
  import rrf_alloc_ctrl_pkg::*;
#(
  parameter int RRF_ENT_SEL = RRF_ENT_SEL_DEF
);
  logic                   i_req_vld_1;
  logic                   i_req_vld_2;
  logic                   o_dp_vld_1;
  logic                   o_dp_vld_2;
  logic [RRF_ENT_SEL-1:0] o_dp_ptr_1;
  logic [RRF_ENT_SEL-1:0] o_dp_ptr_2;
  logic                   o_stall;
  logic [1:0]             i_com_num;
  logic                   i_flush;
  logic [RRF_ENT_SEL:0]   o_freenum;
  logic                   o_err;

  modport slave (
    input  i_req_vld_1, i_req_vld_2, i_com_num, i_flush,
    output o_dp_vld_1, o_dp_vld_2, o_dp_ptr_1, o_dp_ptr_2, o_stall, o_freenum, o_err
  );

  modport master (
    output i_req_vld_1, i_req_vld_2, i_com_num, i_flush,
    input  o_dp_vld_1, o_dp_vld_2, o_dp_ptr_1, o_dp_ptr_2, o_stall, o_freenum, o_err
  );
endinterface

// File: rtl/rrf_alloc_ctrl.sv
// Rename-register-file allocator: in-order ring of entries, dual-slot all-or-nothing grant, flush recovery.
// Optional stall-cycle counter o_stall_cnt is built when RRF_ALLOC_PERF_EN is defined.
module rrf_alloc_ctrl
  import rrf_alloc_ctrl_pkg::*;
#(
  parameter int RRF_ENT_NUM = RRF_ENT_NUM_DEF,
  parameter int RRF_ENT_SEL = RRF_ENT_SEL_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  rrf_alloc_ctrl_if.slave       bus
`ifdef RRF_ALLOC_PERF_EN
  ,
  output logic [31:0]           o_stall_cnt
`endif
);

  localparam logic [RRF_ENT_SEL:0] FULL_CNT = (RRF_ENT_SEL+1)'(RRF_ENT_NUM);

  state_e                 r_state, w_state_next;
  logic [RRF_ENT_SEL-1:0] r_dpptr, r_comptr, w_comptr_next;
  logic [RRF_ENT_SEL:0]   r_freenum, w_live;
  logic                   r_err;
  logic                   w_req_bad, w_grant, w_stall, w_com_bad;
  logic [1:0]             w_req_num, w_alloc_num, w_com_num;

  // Slot 2 alone is malformed: treated as no request and flagged.
  assign w_req_bad = bus.i_req_vld_2 & ~bus.i_req_vld_1;
  assign w_req_num = w_req_bad ? 2'd0 : ({1'b0, bus.i_req_vld_1} + {1'b0, bus.i_req_vld_2});

  assign w_grant = ~rst && (r_state == RUN) && ~bus.i_flush && (w_req_num != 2'd0) &&
                   (r_freenum >= (RRF_ENT_SEL+1)'(w_req_num));
  assign w_stall = ~rst && (w_req_num != 2'd0) && ~w_grant;
  assign w_alloc_num = w_grant ? w_req_num : 2'd0;

  // Retiring more than the live count means an unallocated entry was committed.
  assign w_live        = FULL_CNT - r_freenum;
  assign w_com_bad     = (r_state == RUN) && ((RRF_ENT_SEL+1)'(bus.i_com_num) > w_live);
  assign w_com_num     = ((r_state == RUN) && !w_com_bad) ? bus.i_com_num : 2'd0;
  assign w_comptr_next = r_comptr + RRF_ENT_SEL'(w_com_num);

  assign bus.o_dp_vld_1 = w_grant & bus.i_req_vld_1;
  assign bus.o_dp_vld_2 = w_grant & bus.i_req_vld_2;
  assign bus.o_dp_ptr_1 = r_dpptr;
  assign bus.o_dp_ptr_2 = r_dpptr + RRF_ENT_SEL'(1);
  assign bus.o_stall    = w_stall;
  assign bus.o_freenum  = r_freenum;
  assign bus.o_err      = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_next;
  end

  // NOTE: every variable of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:     if (bus.i_flush) w_state_next = RECOVER;
      RECOVER: w_state_next = bus.i_flush ? RECOVER : RUN;
      default: w_state_next = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dpptr   <= '0;
      r_comptr  <= '0;
      r_freenum <= FULL_CNT;
      r_err     <= 1'b0;
    end else begin
      r_comptr <= w_comptr_next;
      if ((r_state == RUN) && bus.i_flush) begin
        r_dpptr   <= w_comptr_next;
        r_freenum <= FULL_CNT;
      end else begin
        r_dpptr   <= r_dpptr + RRF_ENT_SEL'(w_alloc_num);
        r_freenum <= r_freenum - (RRF_ENT_SEL+1)'(w_alloc_num) + (RRF_ENT_SEL+1)'(w_com_num);
      end
      if (w_com_bad || w_req_bad) r_err <= 1'b1;
    end
  end

`ifdef RRF_ALLOC_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             o_stall_cnt <= '0;
    else if (w_stall && ~&o_stall_cnt)   o_stall_cnt <= o_stall_cnt + 32'd1;
  end
`endif

endmodule
